cordic_pipe: RTL and testbench
==============================

CORDIC_PIPE -- requirements
Module: cordic_pipe

Interface
REQ-001 Parameter W, default 32: data and angle width in bits, two's complement.
REQ-002 Parameter STAGES, default 16, range 4..W-2: number of micro-rotation stages, which is also the pipeline depth.
REQ-003 Parameter ANG_FRAC, default 29: fractional bits of z, in radians.
REQ-004 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: input sample present.
REQ-007 Port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-008 Port in_mode, input, 1 bit: 0 = rotation, 1 = vectoring.
REQ-009 Ports x_in, y_in, z_in, input, W bits each, signed: operands.
REQ-010 Port out_valid, output, 1 bit: result present.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 Port out_mode, output, 1 bit: in_mode carried with the sample.
REQ-013 Ports x_out, y_out, z_out, output, W bits each, signed: results.

Function
REQ-014 Internal constant table ATAN[i], for i = 0..STAGES-1, SHALL equal round(atan(2^-i) * 2^ANG_FRAC), held as W-bit signed values.
REQ-015 Each stage i SHALL hold one registered slot: valid, mode, x, y, z.
REQ-016 Direction d for stage i: in rotation mode d = +1 iff z > 0 (strict), otherwise d = -1.
REQ-017 Direction d for stage i: in vectoring mode d = +1 iff y < 0, otherwise d = -1.
REQ-018 Stage i update: x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*ATAN[i].
REQ-019 Shifts SHALL be arithmetic, and all sums SHALL wrap modulo 2^W with no saturation and no width growth.
REQ-020 Global advance enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-021 When en = 1, every slot SHALL shift one stage forward, and stage 0 SHALL load {in_valid, in_mode, x_in, y_in, z_in}.
REQ-022 When en = 0, all slots SHALL hold their values, including data and valid bits.
REQ-023 Data registers SHALL update whenever en = 1, regardless of valid; only the valid bits are architecturally significant.
REQ-024 Outputs SHALL be driven directly from the last stage's registers, with no combinational path from inputs.
REQ-025 With out_ready held at 1, latency from an accepted input to out_valid SHALL be exactly STAGES cycles.
REQ-026 Throughput SHALL be one sample per cycle; modes may be mixed on consecutive samples.
REQ-027 A transfer occurs on in_valid && in_ready (input side) or out_valid && out_ready (output side); there are no other transfers.
REQ-028 Samples SHALL never be dropped, duplicated or reordered.
REQ-029 Output stability: while out_valid = 1 and out_ready = 0, all outputs SHALL remain stable.
REQ-030 Pipeline bubbles (in_valid = 0 accepted) SHALL propagate as invalid slots and never assert out_valid.
REQ-031 Operand limits are the caller's contract: |x|, |y| < 2^(W-2)/1.647; rotation |z| <= 1.74 rad; vectoring x_in > 0.
REQ-032 Outside the limits of REQ-031 the results are wrapped values, not errors.
REQ-033 Results carry the CORDIC gain K (approx. 1.64676 for STAGES >= 10); the block SHALL NOT compensate for it.

Reset
REQ-034 rst_n = 0 SHALL immediately, without waiting for a clock edge, clear every stage valid bit.
REQ-035 During reset, out_valid = 0, in_ready = 1, and x_out, y_out, z_out, out_mode = 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight samples, and no result SHALL emerge for them.
REQ-037 The first sample accepted after rst_n rises SHALL appear after exactly STAGES cycles.

Verification (W=32, STAGES=16, ANG_FRAC=29; tolerance ±2^14 on z, ±64 on x/y)
REQ-038 Rotation scenario: x=1048576, y=0, z=0 -> x_out approx. 1726751, y_out approx. 0, out_mode=0, out_valid exactly 16 cycles later.
REQ-039 Vectoring scenario: x=1048576, y=1048576, z=0 -> x_out approx. 2442000, y_out approx. 0, z_out approx. 421657428 (pi/4).
REQ-040 Streaming scenario: 64 back-to-back samples alternating modes against a reference model -> all match within tolerance, in order, with no gaps.
REQ-041 Backpressure scenario: random out_ready at 50% duty while streaming -> outputs stable while stalled, in_ready equals en every cycle, no loss or duplication.
REQ-042 Reset scenario: assert rst_n low for 1 cycle while 10 samples are in flight -> out_valid drops asynchronously, none of those samples appear, and the next sample emerges after 16 cycles.
REQ-043 Boundary scenario: rotation with z=0 (d=-1 at stage 0), and y=0 in vectoring mode (d=-1) -> match the reference model bit-exactly.

Source files
------------

// File: rtl/cordic_pipe.sv
// -----------------------------------------------------------------------------
// cordic_pipe -- fully pipelined CORDIC engine, one micro-rotation per stage.
//
// Each of the STAGES pipeline slots holds {valid, mode, x, y, z}. A sample
// enters stage 0 already rotated by micro-rotation 0, so a sample accepted in
// cycle c is presented on the outputs in cycle c + STAGES. The whole pipe
// advances together whenever the last slot is empty or being consumed.
//
// mode 0 (rotation) : drives z towards 0,  rotating (x, y) by the input angle.
// mode 1 (vectoring): drives y towards 0,  accumulating the vector angle in z.
// Results carry the CORDIC gain; no gain compensation is applied.
//
// Parameters
//   W        data/angle width (two's complement)
//   STAGES   number of micro-rotations = pipeline depth (4 .. W-2)
//   ANG_FRAC fractional bits of z, in radians
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready is the global advance enable)
//   in_mode              0 = rotation, 1 = vectoring
//   x_in, y_in, z_in     signed operands
//   out_valid/out_ready  output handshake
//   out_mode             mode carried with the sample
//   x_out, y_out, z_out  signed results, straight from the last stage registers
// -----------------------------------------------------------------------------
module cordic_pipe #(
  parameter int W        = 32,
  parameter int STAGES   = 16,
  parameter int ANG_FRAC = 29
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_mode,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out
);

  typedef logic signed [W-1:0] word_t;

  typedef struct packed {
    logic                valid;
    logic                mode;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
  } slot_t;

  // ---------------------------------------------------------------------------
  // Arctangent table, evaluated at elaboration time.
  // atan(1/q) is summed as a Taylor series in 100-bit fixed point, which leaves
  // far more guard bits than any sensible ANG_FRAC needs before rounding.
  // atan(1) = atan(1/2) + atan(1/3) keeps the i = 0 series fast-converging.
  // ---------------------------------------------------------------------------
  localparam int FIX = 100;

  function automatic logic [127:0] atan_recip(input logic [127:0] q);
    logic [127:0] term;
    logic [127:0] q2;
    logic [127:0] sum;
    int           k;
    q2   = q * q;
    term = (128'(1) << FIX) / q;
    sum  = '0;
    k    = 0;
    while (term != '0) begin
      if (k % 2 == 0) sum = sum + term / 128'(2 * k + 1);
      else            sum = sum - term / 128'(2 * k + 1);
      term = term / q2;
      k++;
    end
    return sum;
  endfunction

  function automatic logic [W-1:0] atan_entry(input int i);
    logic [127:0] a;
    if (i == 0) a = atan_recip(128'd2) + atan_recip(128'd3);
    else        a = atan_recip(128'(1) << i);
    // Round to nearest at ANG_FRAC fractional bits.
    return W'((a + (128'(1) << (FIX - 1 - ANG_FRAC))) >> (FIX - ANG_FRAC));
  endfunction

  function automatic logic [STAGES-1:0][W-1:0] atan_table();
    logic [STAGES-1:0][W-1:0] t;
    t = '0;
    for (int i = 0; i < STAGES; i++)
      t = t | ((STAGES * W)'(atan_entry(i)) << (i * W));
    return t;
  endfunction

  localparam logic [STAGES-1:0][W-1:0] ATAN = atan_table();

  // ---------------------------------------------------------------------------
  // One micro-rotation by +/- atan(2^-sh). Data is rotated regardless of the
  // valid bit; only valid matters architecturally. All sums wrap at W bits.
  // ---------------------------------------------------------------------------
  function automatic slot_t rotate(input slot_t s, input word_t ang,
                                   input int unsigned sh);
    word_t x_sh;
    word_t y_sh;
    logic  d_pos;
    // NOTE: every output field gets a default before any conditional update,
    // so no path leaves a value unassigned and no latch can be inferred.
    rotate = s;
    x_sh   = $signed(s.x) >>> sh;
    y_sh   = $signed(s.y) >>> sh;
    // Rotation: d = +1 only for strictly positive z. Vectoring: d = +1 iff y < 0.
    d_pos  = s.mode ? s.y[W-1] : (!s.z[W-1] && (s.z != '0));
    if (d_pos) begin
      rotate.x = s.x - y_sh;
      rotate.y = s.y + x_sh;
      rotate.z = s.z - ang;
    end else begin
      rotate.x = s.x + y_sh;
      rotate.y = s.y - x_sh;
      rotate.z = s.z + ang;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  slot_t                   in_slot;
  slot_t [STAGES-1:0]      pipe_q;     // registered slots, [STAGES-1] drives outputs
  slot_t [STAGES-1:0]      src_chain;  // source feeding each stage's rotator
  slot_t [STAGES-1:0]      pipe_d;     // rotated values waiting to be registered
  logic                    en;

  assign in_slot   = '{valid: in_valid, mode: in_mode, x: x_in, y: y_in, z: z_in};
  assign src_chain = {pipe_q[STAGES-2:0], in_slot};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign pipe_d[i] = rotate(src_chain[i], ATAN[i], i);
  end

  // Whole pipe moves when the last slot is empty or is being taken this cycle.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data fields are cleared along with the valid bits so the outputs
      // read as zero while reset is held; data is otherwise don't-care when
      // not valid.
      pipe_q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignment -- every slot samples its predecessor's
      // pre-edge value, which is what makes this a shift rather than a ripple.
      pipe_q <= pipe_d;
    end
  end

  assign out_valid = pipe_q[STAGES-1].valid;
  assign out_mode  = pipe_q[STAGES-1].mode;
  assign x_out     = pipe_q[STAGES-1].x;
  assign y_out     = pipe_q[STAGES-1].y;
  assign z_out     = pipe_q[STAGES-1].z;

endmodule

// File: tb/tb_cordic_pipe.sv
// -----------------------------------------------------------------------------
// tb_cordic_pipe -- scoreboard bench for cordic_pipe (W=32, STAGES=16,
// ANG_FRAC=29). The driver computes each expected result with an integer
// CORDIC reference built from a real-valued arctangent table and pushes it;
// an independent monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_cordic_pipe;

  localparam int W        = 32;
  localparam int STAGES   = 16;
  localparam int ANG_FRAC = 29;
  localparam int LIM_XY   = 600000000;  // below 2^30 / 1.647
  localparam int LIM_Z    = 900000000;  // below 1.74 rad at 2^29

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                in_valid  = 1'b0;
  logic                in_mode   = 1'b0;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] x_in      = '0;
  logic signed [W-1:0] y_in      = '0;
  logic signed [W-1:0] z_in      = '0;
  logic                in_ready;
  logic                out_valid;
  logic                out_mode;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] z_out;

  cordic_pipe #(.W(W), .STAGES(STAGES), .ANG_FRAC(ANG_FRAC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode;
    int x, y, z;       // bit-exact expected result
    int acc_cyc;       // cycle count at acceptance
    bit lat;           // check fixed latency (no backpressure in flight)
    bit tol;           // also check against closed-form targets
    int tx, ty, tz;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;  // 0: out_ready=1, 1: random 50%
  int   atan_tab[STAGES];
  logic                prev_stall = 1'b0;
  logic [3*W+1:0]      prev_bus   = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 1) == 1);
    else               out_ready = 1'b1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input longint tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Reference: iterate the micro-rotation rules on 32-bit wrapping integers.
  task automatic model(input bit m, input int x0, input int y0, input int z0,
                       output int xr, output int yr, output int zr);
    int x, y, z, xn;
    bit d_pos;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < STAGES; i++) begin
      d_pos = m ? (y < 0) : (z > 0);
      xn = d_pos ? x - (y >>> i) : x + (y >>> i);
      y  = d_pos ? y + (x >>> i) : y - (x >>> i);
      z  = d_pos ? z - atan_tab[i] : z + atan_tab[i];
      x  = xn;
    end
    xr = x; yr = y; zr = z;
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  // Present one sample from posedge+1, wait for acceptance, return at posedge+1.
  task automatic send(input bit m, input int x, input int y, input int z,
                      input bit lat, input bit tol,
                      input int tx, input int ty, input int tz);
    exp_t e;
    int   guard;
    in_valid = 1'b1; in_mode = m; x_in = x; y_in = y; z_in = z;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 1000);
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      e.mode = m; e.acc_cyc = cyc; e.lat = lat; e.tol = tol;
      e.tx = tx; e.ty = ty; e.tz = tz;
      model(m, x, y, z, e.x, e.y, e.z);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit m, input bit lat);
    int x;
    x = m ? int'($urandom_range(1, LIM_XY)) : rnd(LIM_XY);
    send(m, x, rnd(LIM_XY), m ? rnd(LIM_Z) : rnd(LIM_Z), lat, 1'b0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_mode"},  out_mode,  0);
    check({tag, "_x_out"},     x_out,     0);
    check({tag, "_y_out"},     y_out,     0);
    check({tag, "_z_out"},     z_out,     0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_eq_en", in_ready, !out_valid || out_ready);
      if (prev_stall)
        check("stall_hold", prev_bus == {out_valid, out_mode, x_out, y_out, z_out}, 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          me = sb.pop_front();
          check("out_mode", out_mode, me.mode);
          check("x_out", x_out, me.x);
          check("y_out", y_out, me.y);
          check("z_out", z_out, me.z);
          if (me.lat) check("latency", cyc - me.acc_cyc, STAGES);
          if (me.tol) begin
            check_tol("x_closed_form", x_out, me.tx, 64);
            check_tol("y_closed_form", y_out, me.ty, 64);
            check_tol("z_closed_form", z_out, me.tz, 16384);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_bus   = {out_valid, out_mode, x_out, y_out, z_out};
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < STAGES; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * (2.0 ** ANG_FRAC) + 0.5);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed rotation and vectoring, first one right after reset release
    send(1'b0, 1048576, 0, 0, 1'b1, 1'b1, 1726751, 0, 0);
    send(1'b1, 1048576, 1048576, 0, 1'b1, 1'b1, 2442000, 0, 421657428);
    drain();

    // Direction boundaries: rotation z = 0, vectoring y = 0, mixed signs
    send(1'b0, 300000, -200000, 0, 1'b1, 1'b0, 0, 0, 0);
    send(1'b1, 700000, 0, 5000, 1'b1, 1'b0, 0, 0, 0);
    send(1'b0, -450000, 123456, -800000000, 1'b1, 1'b0, 0, 0, 0);
    send(1'b1, 1, -1, 0, 1'b1, 1'b0, 0, 0, 0);
    send(1'b0, LIM_XY, LIM_XY, LIM_Z, 1'b1, 1'b0, 0, 0, 0);
    drain();

    // 64 back-to-back samples alternating modes; fixed latency means no gaps
    for (int i = 0; i < 64; i++) send_rand(i[0], 1'b1);
    drain();

    // Random backpressure with bubbles
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      send_rand($urandom_range(0, 1) == 1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rdy_mode = 0;
    idle(2);

    // Reset with samples in flight
    for (int i = 0; i < 20; i++) send_rand(i[0], 1'b1);
    @(negedge clk);
    check("valid_before_reset", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 1048576, 0, 0, 1'b1, 1'b1, 1726751, 0, 0);
    idle(40);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
